// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: core load/store/fill front end for a single-port registered-read SRAM
module mem_req_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [ADDR_WIDTH:0]   req_len,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_CAP, WR, FILL, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  resp_valid_q, resp_valid_d, resp_err_q, resp_err_d, mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d, mem_din_q, mem_din_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  is_rd, is_wr, is_fill;
  assign is_rd   = req_op == 2'b00;
  assign is_wr   = req_op == 2'b01;
  assign is_fill = req_op == 2'b10 && req_len != '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = is_rd ? RD_ADDR : is_wr ? WR : is_fill ? FILL : RESP;
      RD_ADDR: state_d = RD_CAP;
      RD_CAP:  state_d = RESP;
      WR:      state_d = RESP;
      FILL:    state_d = cnt_q == '0 ? RESP : FILL;
      RESP:    state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // cnt_q holds the writes still to issue after the one currently on the bus
  always_comb begin
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (is_rd || is_wr || is_fill) mem_addr_d = req_addr;
        if (is_wr || is_fill) begin
          mem_we_d  = 1'b1;
          mem_din_d = req_wdata;
        end
        if (is_fill) cnt_d = req_len - 1'b1;
        if (!(is_rd || is_wr || is_fill)) begin
          resp_valid_d = 1'b1;
          resp_err_d   = req_op == 2'b11;
          resp_data_d  = '0;
        end
      end
      RD_CAP: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = mem_dout;
      end
      WR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = '0;
      end
      FILL: if (cnt_q == '0) begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = '0;
      end else begin
        mem_we_d   = 1'b1;
        mem_addr_d = mem_addr_q + 1'b1;
        cnt_d      = cnt_q - 1'b1;
      end
      RESP: if (resp_ready) begin
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
      end
      default: ;
    endcase
  end
  assign req_ready  = state_q == IDLE;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed bench for mem_req_ctrl with a behavioural registered-read SRAM
module tb_mem_req_ctrl;
  localparam int DW = 32;
  localparam int AW = 8;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, resp_ready = 1'b0;
  logic [1:0]    req_op = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [AW:0]   req_len = '0;
  logic          req_ready, resp_valid, resp_err, mem_we;
  logic [DW-1:0] resp_data, mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [256] = '{default: '0};
  int errors = 0;
  int checks = 0;
  mem_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [AW:0] len);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d; req_len = len;
    step;
    req_valid = 1'b0;
  endtask
  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    step;
    resp_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_hs_ready"}, 32'(req_ready), 32'd1);
  endtask
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    send(2'b00, a, '0, '0);
    chk({tag, "_c1"}, 32'(resp_valid), 32'd0);
    step;
    chk({tag, "_c2"}, 32'(resp_valid), 32'd0);
    step;
    chk({tag, "_c3"}, 32'(resp_valid), 32'd1);
    chk({tag, "_data"}, resp_data, exp);
    chk({tag, "_err"}, 32'(resp_err), 32'd0);
    finish_resp(tag);
  endtask
  task automatic txn(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] exp, input string tag);
    int n = 0;
    send(op, a, d, '0);
    while (!resp_valid && n < 10) begin
      step;
      n++;
    end
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_data"}, resp_data, exp);
    step;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    step;
    step;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    rst = 1'b0;
    step;
    send(2'b01, 8'h05, 32'hDEADBEEF, '0);
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_addr", 32'(mem_addr), 32'h05);
    chk("wr_din", mem_din, 32'hDEADBEEF);
    chk("wr_ready_busy", 32'(req_ready), 32'd0);
    step;
    chk("wr_we_drop", 32'(mem_we), 32'd0);
    chk("wr_resp_valid", 32'(resp_valid), 32'd1);
    chk("wr_resp_data", resp_data, 32'd0);
    chk("wr_resp_err", 32'(resp_err), 32'd0);
    finish_resp("wr");
    do_read(8'h05, 32'hDEADBEEF, "rd05");
    send(2'b10, 8'hFE, 32'h11, 9'd4);
    chk("fill_we0", 32'(mem_we), 32'd1);
    chk("fill_a0", 32'(mem_addr), 32'hFE);
    step;
    chk("fill_we1", 32'(mem_we), 32'd1);
    chk("fill_a1", 32'(mem_addr), 32'hFF);
    step;
    chk("fill_a2", 32'(mem_addr), 32'h00);
    step;
    chk("fill_we3", 32'(mem_we), 32'd1);
    chk("fill_a3", 32'(mem_addr), 32'h01);
    chk("fill_rv3", 32'(resp_valid), 32'd0);
    step;
    chk("fill_we_end", 32'(mem_we), 32'd0);
    chk("fill_rv_end", 32'(resp_valid), 32'd1);
    finish_resp("fill");
    do_read(8'hFE, 32'h11, "rdFE");
    do_read(8'hFF, 32'h11, "rdFF");
    do_read(8'h00, 32'h11, "rd00");
    do_read(8'h01, 32'h11, "rd01");
    do_read(8'h02, 32'h0, "rd02");
    send(2'b10, 8'h30, 32'h77, 9'd0);
    chk("fill0_we", 32'(mem_we), 32'd0);
    chk("fill0_rv", 32'(resp_valid), 32'd1);
    chk("fill0_err", 32'(resp_err), 32'd0);
    finish_resp("fill0");
    send(2'b11, 8'h31, 32'h55, '0);
    chk("ill_we", 32'(mem_we), 32'd0);
    chk("ill_rv", 32'(resp_valid), 32'd1);
    chk("ill_err", 32'(resp_err), 32'd1);
    chk("ill_data", resp_data, 32'd0);
    finish_resp("ill");
    chk("ill_err_clr", 32'(resp_err), 32'd0);
    do_read(8'h30, 32'h0, "rd30");
    send(2'b00, 8'h05, '0, '0);
    step;
    step;
    req_valid = 1'b1; req_op = 2'b00; req_addr = 8'hFE;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rv", 32'(resp_valid), 32'd1);
      chk("hold_data", resp_data, 32'hDEADBEEF);
      chk("hold_ready", 32'(req_ready), 32'd0);
      step;
    end
    resp_ready = 1'b1;
    step;
    resp_ready = 1'b0;
    chk("hold_hs_rv", 32'(resp_valid), 32'd0);
    chk("hold_hs_ready", 32'(req_ready), 32'd1);
    step;
    chk("second_acc", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    step;
    chk("second_c2", 32'(resp_valid), 32'd0);
    step;
    chk("second_rv", 32'(resp_valid), 32'd1);
    chk("second_data", resp_data, 32'h11);
    finish_resp("second");
    send(2'b10, 8'h00, 32'hA5A5A5A5, 9'd256);
    chk("big_a0", 32'(mem_addr), 32'h00);
    for (int i = 0; i < 10; i++) step;
    chk("big_we10", 32'(mem_we), 32'd1);
    chk("big_a10", 32'(mem_addr), 32'h0A);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", 32'(mem_we), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_rv", 32'(resp_valid), 32'd0);
    step;
    rst = 1'b0;
    step;
    do_read(8'h05, 32'hA5A5A5A5, "post05");
    do_read(8'h09, 32'hA5A5A5A5, "post09");
    do_read(8'h0A, 32'h0, "post0A");
    resp_ready = 1'b1;
    txn(2'b01, 8'h10, 32'd1, 32'd0, "b2b_w10");
    txn(2'b01, 8'h11, 32'd2, 32'd0, "b2b_w11");
    txn(2'b00, 8'h10, '0, 32'd1, "b2b_r10");
    txn(2'b00, 8'h11, '0, 32'd2, "b2b_r11");
    resp_ready = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
